// File: rtl/airlock_pkg.sv
// airlock_pkg
// Shared types and constants for the airlock cycle controller:
//   state_t   - sequencer states
//   outs_t    - bundle of Moore outputs (busy, pumps, display)
//   SEG_*     - active-low 7-segment codes, bit order gfedcba
//   decode()  - maps a state and direction to the output bundle
package airlock_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EVAC     = 3'd1,
        VAC_OPEN = 3'd2,
        VAC_IN   = 3'd3,
        VAC_HOLD = 3'd4,
        PRESS    = 3'd5,
        FAULT    = 3'd6
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_F     = 7'b0001110;

    typedef struct packed {
        logic       busy;
        logic       pump_out;
        logic       pump_in;
        logic [6:0] display;
    } outs_t;

    function automatic outs_t decode(input state_t s, input logic d);
        outs_t o;
        o = '{busy: 1'b1, pump_out: 1'b0, pump_in: 1'b0, display: SEG_BLANK};
        case (s)
            IDLE:     o.busy = 1'b0;
            EVAC:     begin o.pump_out = 1'b1; o.display = SEG_E; end
            VAC_OPEN,
            VAC_IN:   o.display = d ? SEG_L : SEG_A;
            VAC_HOLD: o.display = SEG_BLANK;
            PRESS:    begin o.pump_in = 1'b1; o.display = SEG_P; end
            FAULT:    o.display = SEG_F;
            default:  o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/airlock_timer.sv
// airlock_timer
// Phase timer shared by the evacuation and pressurisation phases.
//   clock  - system clock
//   rst    - synchronous active-low reset
//   clear  - holds prescaler and tick counter at zero
//   target - phase length in ticks
//   done   - high on the last clock cycle of the phase
module airlock_timer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clear,
    input  logic [CNT_W-1:0] target,
    output logic             done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] tick;
    logic             wrap;

    assign wrap = (pre == PRE_MAX);
    assign done = wrap && (tick == (target - CNT_W'(1)));

    always_ff @(posedge clock) begin
        if (!rst || clear) begin
            pre  <= '0;
            tick <= '0;
        end else if (wrap) begin
            pre  <= '0;
            tick <= tick + CNT_W'(1);
        end else begin
            pre  <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/airlock_cycle_ctrl.sv
// airlock_cycle_ctrl
// Bidirectional airlock sequencer: evacuate, let the craft through the
// outer door, then repressurise. One shared phase timer.
//   clock, rst             - system clock, synchronous active-low reset
//   innerPort, outerPort   - door-open sensors
//   leaving, arriving      - craft requests (arriving wins if both)
//   evac, pressurize       - operator commands (level-sensitive)
//   busy, dir              - sequence active, latched direction (1 = leaving)
//   pump_out, pump_in      - pump drives for EVAC and PRESS
//   display                - active-low 7-segment status, gfedcba
// Build option: AIRLOCK_FAULT_DETECT_EN adds a FAULT state, entered when a
// door opens during a pump phase or the inner door opens while vacuum is
// exposed to the outer port; only reset leaves it.
//
// state    | meaning
// IDLE     | chamber pressurised, waiting for a request plus evac
// EVAC     | pumping chamber down for EVAC_TICKS ticks
// VAC_OPEN | vacuum reached, waiting for the outer door to open
// VAC_IN   | outer door open, craft transiting
// VAC_HOLD | outer door closed, waiting for pressurize and request release
// PRESS    | pumping chamber up for PRESS_TICKS ticks
// FAULT    | door breach during a sequence, held until reset
module airlock_cycle_ctrl
    import airlock_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TICK_DIV    = 1,
    parameter int EVAC_TICKS  = 2,
    parameter int PRESS_TICKS = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       innerPort,
    input  logic       outerPort,
    input  logic       leaving,
    input  logic       arriving,
    input  logic       evac,
    input  logic       pressurize,
    output logic       busy,
    output logic       dir,
    output logic       pump_out,
    output logic       pump_in,
    output logic [6:0] display
);

    state_t           state, nxt;
    logic             nxt_dir;
    outs_t            nxt_outs;
    logic             timer_clear;
    logic             timer_done;
    logic [CNT_W-1:0] timer_target;
    logic             doors_shut;

    assign doors_shut   = ~innerPort & ~outerPort;
    // Timer runs only inside a pump phase; EVAC and PRESS are never adjacent,
    // so holding it clear elsewhere gives a fresh count on every entry.
    assign timer_clear  = !(state == EVAC || state == PRESS);
    assign timer_target = (state == PRESS) ? CNT_W'(PRESS_TICKS) : CNT_W'(EVAC_TICKS);

    airlock_timer #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clock  (clock),
        .rst    (rst),
        .clear  (timer_clear),
        .target (timer_target),
        .done   (timer_done)
    );

    always_comb begin
        nxt     = state;
        nxt_dir = dir;
        case (state)
            IDLE: begin
                if ((leaving | arriving) & evac & doors_shut) begin
                    nxt     = EVAC;
                    nxt_dir = leaving & ~arriving;
                end
            end
            EVAC: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                if (!doors_shut)     nxt = FAULT;
                else
`endif
                if (timer_done)      nxt = VAC_OPEN;
            end
            VAC_OPEN: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                if (innerPort)       nxt = FAULT;
                else
`endif
                if (outerPort & ~innerPort) nxt = VAC_IN;
            end
            VAC_IN: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                if (innerPort)       nxt = FAULT;
                else
`endif
                if (~outerPort)      nxt = VAC_HOLD;
            end
            VAC_HOLD: begin
                if (pressurize & doors_shut & ~(dir ? leaving : arriving))
                    nxt = PRESS;
            end
            PRESS: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                if (!doors_shut)     nxt = FAULT;
                else
`endif
                if (timer_done)      nxt = IDLE;
            end
`ifdef AIRLOCK_FAULT_DETECT_EN
            FAULT:   nxt = FAULT;
`endif
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state
    // register exactly, with no combinational path from inputs.
    assign nxt_outs = decode(nxt, nxt_dir);

    always_ff @(posedge clock) begin
        if (!rst) begin
            state    <= IDLE;
            dir      <= 1'b0;
            busy     <= 1'b0;
            pump_out <= 1'b0;
            pump_in  <= 1'b0;
            display  <= SEG_BLANK;
        end else begin
            state    <= nxt;
            dir      <= nxt_dir;
            busy     <= nxt_outs.busy;
            pump_out <= nxt_outs.pump_out;
            pump_in  <= nxt_outs.pump_in;
            display  <= nxt_outs.display;
        end
    end

endmodule

// File: tb/tb_airlock_cycle_ctrl.sv
module tb_airlock_cycle_ctrl;

    localparam int EV = 2;
    localparam int PR = 4;

    logic clock = 1'b0;
    logic rst = 1'b0;
    logic innerPort = 1'b0, outerPort = 1'b0;
    logic leaving = 1'b0, arriving = 1'b0;
    logic evac = 1'b0, pressurize = 1'b0;

    logic [1:0] d_busy, d_dir, d_pout, d_pin;
    logic [6:0] d_disp [2];

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    airlock_cycle_ctrl u0 (
        .clock(clock), .rst(rst), .innerPort(innerPort), .outerPort(outerPort),
        .leaving(leaving), .arriving(arriving), .evac(evac), .pressurize(pressurize),
        .busy(d_busy[0]), .dir(d_dir[0]), .pump_out(d_pout[0]), .pump_in(d_pin[0]),
        .display(d_disp[0])
    );

    airlock_cycle_ctrl #(.TICK_DIV(3)) u1 (
        .clock(clock), .rst(rst), .innerPort(innerPort), .outerPort(outerPort),
        .leaving(leaving), .arriving(arriving), .evac(evac), .pressurize(pressurize),
        .busy(d_busy[1]), .dir(d_dir[1]), .pump_out(d_pout[1]), .pump_in(d_pin[1]),
        .display(d_disp[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: phase number plus a countdown of remaining cycles.
    // 0 idle, 1 pumping down, 2 vacuum/outer shut, 3 outer open,
    // 4 holding, 5 pumping up, 6 fault.
    int  m_phase [2];
    int  m_left  [2];
    bit  m_dir   [2];
    int  tdiv    [2] = '{1, 3};

    for (genvar g = 0; g < 2; g++) begin : g_model
        always @(posedge clock) begin
            int  p, l;
            bit  d;
            bit  shut;
            p = m_phase[g]; l = m_left[g]; d = m_dir[g];
            shut = !innerPort && !outerPort;
            if (!rst) begin
                p = 0; d = 0;
            end else begin
                case (p)
                    0: if ((leaving || arriving) && evac && shut) begin
                           p = 1; l = EV * tdiv[g]; d = leaving && !arriving;
                       end
                    1: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                           if (!shut) p = 6; else
`endif
                           begin l--; if (l == 0) p = 2; end
                       end
                    2: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                           if (innerPort) p = 6; else
`endif
                           if (outerPort && !innerPort) p = 3;
                       end
                    3: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                           if (innerPort) p = 6; else
`endif
                           if (!outerPort) p = 4;
                       end
                    4: if (pressurize && shut && !(d ? leaving : arriving)) begin
                           p = 5; l = PR * tdiv[g];
                       end
                    5: begin
`ifdef AIRLOCK_FAULT_DETECT_EN
                           if (!shut) p = 6; else
`endif
                           begin l--; if (l == 0) p = 0; end
                       end
                    default: p = 6;
                endcase
            end
            m_phase[g] <= p; m_left[g] <= l; m_dir[g] <= d;
        end
    end

    function automatic logic [6:0] exp_disp(input int p, input bit d);
        case (p)
            1: return 7'b0000110;
            2, 3: return d ? 7'b1000111 : 7'b0001000;
            5: return 7'b0001100;
            6: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy[%0d]", i), int'(d_busy[i]), int'(m_phase[i] != 0));
                chk($sformatf("dir[%0d]", i), int'(d_dir[i]), int'(m_dir[i]));
                chk($sformatf("pump_out[%0d]", i), int'(d_pout[i]), int'(m_phase[i] == 1));
                chk($sformatf("pump_in[%0d]", i), int'(d_pin[i]), int'(m_phase[i] == 5));
                chk($sformatf("display[%0d]", i), int'(d_disp[i]), int'(exp_disp(m_phase[i], m_dir[i])));
            end
        end
    end

    // Length of the most recent pump_out / pump_in runs on each instance.
    int run_ev [2] = '{0, 0};
    int run_pr [2] = '{0, 0};
    int ev_len [2] = '{0, 0};
    int pr_len [2] = '{0, 0};

    always @(posedge clock) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (d_pout[i] === 1'b1) run_ev[i]++;
            else if (run_ev[i] != 0) begin ev_len[i] = run_ev[i]; run_ev[i] = 0; end
            if (d_pin[i] === 1'b1) run_pr[i]++;
            else if (run_pr[i] != 0) begin pr_len[i] = run_pr[i]; run_pr[i] = 0; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pumps_off();
        int n = 0;
        while ((d_pout !== 2'b00 || d_pin !== 2'b00) && n < 100) begin
            tick(1); n++;
        end
        if (n >= 100) chk("pump_timeout", n, 0);
    endtask

    task automatic clear_inputs();
        innerPort = 0; outerPort = 0; leaving = 0; arriving = 0;
        evac = 0; pressurize = 0;
    endtask

    // Walk both instances from IDLE through the outer-door transit to VAC_HOLD.
    task automatic to_hold(input bit lv, input bit ar);
        leaving = lv; arriving = ar; evac = 1; tick(1);
        evac = 0; wait_pumps_off();
        outerPort = 1; tick(1);
        outerPort = 0; tick(1);
    endtask

    initial begin
        clear_inputs();
        rst = 0; tick(2);
        chk_en = 1'b1;
        rst = 1; tick(1);
        chk("rst_busy", int'(d_busy[0]), 0);
        chk("rst_display", int'(d_disp[0]), 7'h7F);
        chk("rst_pumps", int'({d_pout[0], d_pin[0]}), 0);

        // departure
        to_hold(1, 0);
        chk("dep_evac_len", ev_len[0], 2);
        chk("dep_evac_len_div3", ev_len[1], 6);
        chk("dep_dir", int'(d_dir[0]), 1);
        chk("dep_hold_display", int'(d_disp[0]), 7'h7F);
        leaving = 0; tick(1);
        pressurize = 1; tick(1);
        pressurize = 0;
        wait_pumps_off();
        chk("dep_press_len", pr_len[0], 4);
        chk("dep_press_len_div3", pr_len[1], 12);
        chk("dep_idle", int'(d_busy), 0);

        // arrival
        arriving = 1; evac = 1; tick(1);
        evac = 0; wait_pumps_off();
        chk("arr_evac_len_div3", ev_len[1], 6);
        chk("arr_display_A", int'(d_disp[1]), 7'b0001000);
        chk("arr_dir", int'(d_dir[1]), 0);
        outerPort = 1; tick(1); outerPort = 0; tick(1);
        arriving = 0; pressurize = 1; tick(1); pressurize = 0;
        wait_pumps_off();

        // both requests: arriving wins, pressurize blocked until it drops
        to_hold(1, 1);
        chk("both_dir", int'(d_dir[0]), 0);
        leaving = 0; pressurize = 1; tick(3);
        chk("both_hold_blocked", int'(d_pin[0]), 0);
        chk("both_hold_busy", int'(d_busy[0]), 1);
        arriving = 0; tick(1);
        chk("both_press", int'(d_pin[0]), 1);
        pressurize = 0; wait_pumps_off();

        // inner door blocks evacuation
        innerPort = 1; leaving = 1; evac = 1; tick(3);
        chk("inner_blocks_evac", int'(d_busy), 0);
        clear_inputs(); tick(1);

        // outer door blocks pressurisation, then reset aborts PRESS
        to_hold(1, 0);
        leaving = 0; outerPort = 1; pressurize = 1; tick(2);
        chk("outer_blocks_press", int'(d_pin[0]), 0);
        outerPort = 0; tick(1);
        pressurize = 0;
        chk("press_entered", int'(d_pin[0]), 1);
        rst = 0; tick(1);
        chk("rst_abort_pump_in", int'(d_pin[0]), 0);
        chk("rst_abort_busy", int'(d_busy[0]), 0);
        rst = 1; tick(1);

`ifdef AIRLOCK_FAULT_DETECT_EN
        leaving = 1; evac = 1; tick(1);
        evac = 0; outerPort = 1; tick(1);
        chk("fault_display", int'(d_disp[0]), 7'b0001110);
        chk("fault_pumps", int'({d_pout[0], d_pin[0]}), 0);
        clear_inputs(); tick(4);
        chk("fault_held", int'(d_disp[1]), 7'b0001110);
        rst = 0; tick(1); rst = 1; tick(1);
        chk("fault_cleared", int'(d_busy), 0);
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            leaving    = ($urandom_range(0, 1) == 0);
            arriving   = ($urandom_range(0, 2) == 0);
            evac       = ($urandom_range(0, 1) == 0);
            pressurize = ($urandom_range(0, 1) == 0);
            innerPort  = ($urandom_range(0, 7) == 0);
            outerPort  = ($urandom_range(0, 3) == 0);
            rst        = ($urandom_range(0, 149) != 0);
            tick(1);
        end
        clear_inputs(); rst = 1; tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/airlock_cycle_ctrl.md
Name: airlock_cycle_ctrl

Overview:
Parametrised airlock sequencer that handles both departing and arriving craft with one state machine. It contains its own cycle timer, so no external counter is needed, and it drives a 7-segment status digit. It sits between the port sensors and operator switches and the display and port actuators. It is the successor of the single-direction departure sequencer.

Parameters:
CNT_W, 8, width of the internal tick counter.
TICK_DIV, 1, clock cycles per timer tick, must be >= 1.
EVAC_TICKS, 2, length of the evacuation phase in ticks, 1..2^CNT_W-1.
PRESS_TICKS, 4, length of the pressurisation phase in ticks, 1..2^CNT_W-1.

Ports:
clock  in  1  system clock; one clock only.
rst  in  1  reset; synchronous and active-low (asserted when 0).
innerPort  in  1  inner door open.
outerPort  in  1  outer door open.
leaving  in  1  departure request.
arriving  in  1  arrival request.
evac  in  1  operator evacuate command.
pressurize  in  1  operator pressurise command.
busy  out  1  1 in every state except IDLE.
dir  out  1  latched direction: 1 = leaving, 0 = arriving.
pump_out  out  1  1 while in EVAC.
pump_in  out  1  1 while in PRESS.
display  out  7  active-low 7-segment code, gfedcba.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE, dir=0, timer cleared. Outputs: busy=0, pump_out=0, pump_in=0, display=BLANK. Reset mid-sequence aborts immediately.
- Display codes: BLANK=1111111, L=1000111, A=0001000, E=0000110, P=0001100, F=0001110.
- All outputs are Moore outputs, decoded from registered state and dir only.
- IDLE:
  - Move to EVAC when (leaving|arriving) & evac & ~innerPort & ~outerPort.
  - Latch dir=leaving. If both requests are high, arriving wins (dir=0).
  - Display BLANK.
- EVAC:
  - pump_out=1, display E.
  - Stays exactly EVAC_TICKS*TICK_DIV cycles, then goes to VAC_OPEN.
- VAC_OPEN:
  - Display L if dir=1, else A.
  - Move to VAC_IN when outerPort & ~innerPort.
- VAC_IN (outer door open, craft transiting):
  - Display L or A as in VAC_OPEN.
  - Move to VAC_HOLD when ~outerPort.
- VAC_HOLD:
  - Display BLANK.
  - Move to PRESS when pressurize & ~innerPort & ~outerPort & ~(dir ? leaving : arriving). The active request must be released first.
- PRESS:
  - pump_in=1, display P.
  - Stays exactly PRESS_TICKS*TICK_DIV cycles, then goes to IDLE.
- Timer:
  - Cleared on entry to EVAC or PRESS. The prescaler counts 0..TICK_DIV-1 and the tick counter advances on prescaler wrap.
  - done is combinational (tick==target-1 & prescaler==TICK_DIV-1). The FSM leaves the counting state on the edge where done=1.
- evac and pressurize are level-sensitive and ignored outside IDLE and VAC_HOLD.
- Requests that arrive during a sequence are not queued. The requester must hold them until IDLE.
- Undefined state encodings go to IDLE.

Optional Feature:
AIRLOCK_FAULT_DETECT_EN
- Defined: in EVAC or PRESS, innerPort|outerPort goes to FAULT.
  - FAULT: display F, busy=1, pump_out=0, pump_in=0.
  - Exit from FAULT only by reset.
  - innerPort in VAC_OPEN or VAC_IN also goes to FAULT.
- Undefined: the FAULT state does not exist, and door inputs are ignored during EVAC and PRESS.

Decomposition:
- Package airlock_pkg holds:
  - state enum: IDLE, EVAC, VAC_OPEN, VAC_IN, VAC_HOLD, PRESS, FAULT.
  - the seven-segment code constants.
- Sub-module airlock_timer (params CNT_W, TICK_DIV):
  - inputs clock, rst, clear, target[CNT_W-1:0].
  - output done.
  - Instantiated once and shared by EVAC and PRESS.

Test Plan:
1. rst=0 for 1 cycle, then 1 -> busy=0, display=1111111, pumps=0.
2. Departure (defaults: EVAC_TICKS=2, PRESS_TICKS=4, TICK_DIV=1):
   - Drive leaving=1, evac=1 with doors closed.
   - EVAC lasts exactly 2 cycles with pump_out=1, display=0000110, then display=1000111.
   - Open then close the outer door, drop leaving, pulse pressurize.
   - pump_in=1 for exactly 4 cycles, then IDLE.
3. Arrival with TICK_DIV=3: arriving=1, evac=1 -> EVAC lasts 6 cycles, display shows 0001000 in VAC_OPEN, dir=0.
4. Simultaneous leaving=1 and arriving=1 with evac in IDLE -> dir=0. In VAC_HOLD, pressurize is ignored until arriving=0.
5. Interlocks:
   - evac with innerPort=1 in IDLE -> stays IDLE.
   - pressurize while outerPort=1 in VAC_HOLD -> no transition.
   - rst=0 during PRESS -> IDLE next edge, pump_in=0.
6. With AIRLOCK_FAULT_DETECT_EN: outerPort=1 during EVAC -> FAULT next edge, display=0001110, pumps=0. Held there until rst=0.
